ps2_kbd: RTL and testbench
==========================

Name: ps2_kbd

Overview:
Wishbone slave PS/2 keyboard receiver for the terminal: deserialises device-to-host PS/2 frames and buffers scan codes in a small FIFO. Exposes a DEC-style CSR/data register pair at 171000/171002 on the 16-bit CPU bus. Raises a vectored-interrupt request (vector 054 in the interrupt controller) that the interrupt controller acknowledges.
Receive-only: no host-to-device commands, and ps2_clk/ps2_data are inputs.

Parameters:
FIFO_DEPTH, 8, scan-code FIFO entries; power of 2, at least 2.
FILT_LEN, 8, number of consecutive equal samples needed to accept a new ps2_clk level (glitch filter).
TIMEOUT, 50000, wb_clk_i cycles without a ps2_clk falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).

Ports:
wb_clk_i  in  1  system clock, 50 MHz
wb_rst_i  in  1  reset, asynchronous, active-high
wb_adr_i  in  16  bus address; only bit 1 is decoded (strobe pre-qualified externally)
wb_dat_i  in  16  write data
wb_dat_o  out  16  read data
wb_cyc_i  in  1  bus cycle
wb_we_i  in  1  write enable
wb_stb_i  in  1  device strobe
wb_ack_o  out  1  transfer acknowledge
wb_sel_i  in  2  byte selects; a CSR write needs wb_sel_i[0]
irq  out  1  interrupt request to the interrupt controller
iack  in  1  interrupt acknowledge, one-cycle pulse
ps2_clk  in  1  PS/2 clock, asynchronous
ps2_data  in  1  PS/2 data, asynchronous

Behaviour:
- Reset: wb_ack_o=0, wb_dat_o=0, irq=0, FIFO empty, IE=0, ERR=0, OVF=0, receiver in IDLE, filtered clock=1.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - The filtered clock changes only after FILT_LEN identical synchronised samples.
  - A falling edge of the filtered clock is a one-cycle strobe; ps2_data is sampled on that cycle.
- Receiver FSM (counts falling edges):
  - IDLE: data=0 on edge -> DATA, bit count 0. data=1 on edge is ignored and stays IDLE.
  - DATA: shift in LSB first. After 8 bits -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: data=1 and odd parity across the 8 data bits + parity bit -> push byte, IDLE. Otherwise set ERR, discard byte, IDLE.
  - In any state except IDLE, the timeout counter is cleared on each edge. Reaching TIMEOUT -> IDLE, byte discarded, ERR unchanged.
- FIFO:
  - Push happens the cycle after a valid STOP.
  - Push when full: byte dropped, OVF set, contents unchanged.
  - Push and pop in the same cycle: both occur and the count is unchanged, including the full and empty cases.
- Registers:
  - CSR @ offset 0, read: bit15=ERR, bit14=OVF, bit7=DONE (FIFO not empty), bit6=IE, all other bits 0.
  - CSR write (wb_sel_i[0]=1): bit6 sets IE; writing 1 to bit15 or bit14 clears that flag. DONE is read-only.
  - DATA @ offset 2, read: {8'h00, head}. If the FIFO is not empty, the read pops one entry. Empty read returns 0 with no pop.
  - DATA writes are ignored but still acked.
- Bus handshake:
  - wb_ack_o is registered: it asserts the cycle after wb_cyc_i & wb_stb_i & ~wb_ack_o and lasts exactly one cycle.
  - wb_dat_o is valid while wb_ack_o=1; register side effects (pop, flag clear) occur on that same clock edge.
  - Back-to-back strobes give ack every other cycle.
- Interrupt:
  - Request condition is IE & DONE. A rising edge of the condition sets the pending latch, and irq = pending.
  - iack clears pending. If the condition is still true, it must fall and rise again before a new request. Exception: a pop that leaves DONE=1 re-arms the request on the next cycle.
  - Clearing IE, or the condition dropping, clears pending immediately.
  - Setting IE while DONE=1 raises irq on the next cycle.
- Reset mid-frame or mid-bus-cycle: the asynchronous clear forces all reset values and drops any pending ack and FIFO contents.

Decomposition:
- Shared package ps2_pkg: register offsets (CSR=0, DATA=2), CSR bit positions (ERR=15, OVF=14, DONE=7, IE=6), receiver state encoding (IDLE, DATA, PARITY, STOP).
- One sub-module, ps2_rx: synchronisers, filter, FSM and timeout. Outputs rx_byte[7:0], rx_valid (1-cycle pulse) and rx_err (1-cycle pulse).
- FIFO, registers and interrupt logic stay in ps2_kbd.

Test Plan:
- Frame 0x1C with parity 0 and stop 1, bit period 80 us -> CSR reads 0x0080; DATA reads 0x001C; CSR then reads 0x0000.
- IE=1 via a CSR write of 0x0040, then frame 0xF0 -> irq high after the push. Pulse iack -> irq low. DATA read returns 0x00F0 and irq stays low.
- Frame 0x1C with a wrong parity bit -> FIFO stays empty, CSR reads 0x8000. Write 0x8000 -> CSR reads 0x0000.
- Nine frames 0x01..0x09 with FIFO_DEPTH=8 -> CSR reads 0x4080. Eight DATA reads return 0x01..0x08; the ninth read returns 0.
- Abort after 4 data bits, wait TIMEOUT+10 cycles, send full frame 0x5A -> only 0x5A in the FIFO, ERR=0.
- Assert wb_rst_i mid-frame with 3 bytes queued -> CSR reads 0, irq=0. The next full frame is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: bus offsets, CSR bit map, receiver states.
package ps2_pkg;

    localparam logic [15:0] CsrOffset  = 16'd0;
    localparam logic [15:0] DataOffset = 16'd2;

    localparam int unsigned CsrErrBit  = 15;
    localparam int unsigned CsrOvfBit  = 14;
    localparam int unsigned CsrDoneBit = 7;
    localparam int unsigned CsrIeBit   = 6;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: input synchronisers, clock glitch filter,
// frame FSM with mid-frame timeout. Emits one-cycle valid/error pulses per frame.
module ps2_rx #(
    parameter int unsigned FILT_LEN = 8,
    parameter int unsigned TIMEOUT  = 50000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       rx_err_o
);
    import ps2_pkg::*;

    localparam int unsigned FiltW = $clog2(FILT_LEN + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT + 1);

    logic [1:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             filt_q;
    logic [FiltW-1:0] filt_cnt_q;
    logic             fall_q;
    logic             data_s;

    rx_state_e        state_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             par_q;
    logic [ToW-1:0]   to_cnt_q;
    logic             valid_q;
    logic             err_q;
    logic             timeout_hit;

    assign data_s = data_sync_q[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
        end
    end

    // Counts consecutive samples that disagree with the current filtered level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (clk_sync_q[1] == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FiltW'(FILT_LEN - 1)) begin
                filt_q     <= clk_sync_q[1];
                filt_cnt_q <= '0;
                fall_q     <= filt_q;
            end else begin
                filt_cnt_q <= filt_cnt_q + FiltW'(1);
            end
        end
    end

    assign timeout_hit = (state_q != StIdle) && !fall_q && (to_cnt_q == ToW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;

            if (state_q == StIdle || fall_q) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + ToW'(1);
            end

            if (timeout_hit) begin
                state_q <= StIdle;
            end else if (fall_q) begin
                unique case (state_q)
                    StIdle: begin
                        if (!data_s) begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                        end
                    end
                    StData: begin
                        shift_q   <= {data_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= StParity;
                        end
                    end
                    StParity: begin
                        par_q   <= data_s;
                        state_q <= StStop;
                    end
                    StStop: begin
                        if (data_s && (^{shift_q, par_q})) begin
                            valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign rx_byte_o  = shift_q;
    assign rx_valid_o = valid_q;
    assign rx_err_o   = err_q;

endmodule

// File: rtl/ps2_kbd.sv
// Wishbone PS/2 keyboard port: CSR/DATA register pair, scan-code FIFO and
// edge-triggered interrupt request with acknowledge.
module ps2_kbd #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FILT_LEN   = 8,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    input  logic [1:0]  wb_sel_i,
    output logic        irq,
    input  logic        iack,
    input  logic        ps2_clk,
    input  logic        ps2_data
);
    import ps2_pkg::*;

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [7:0]      rx_byte;
    logic            rx_valid;
    logic            rx_err;

    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            ack_q;
    logic [15:0]     dat_q;
    logic            ie_q, ie_d;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
    logic            cond_q, cond_d;
    logic            pend_q, pend_d;

    logic            empty, full;
    logic            bus_req, sel_data, data_rd, csr_wr;
    logic            pop, wr_en, ovf_set;
    logic [7:0]      head;
    logic [15:0]     csr_rd, rd_val;
    logic            unused_bits;

    ps2_rx #(
        .FILT_LEN (FILT_LEN),
        .TIMEOUT  (TIMEOUT)
    ) u_rx (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .rx_byte_o  (rx_byte),
        .rx_valid_o (rx_valid),
        .rx_err_o   (rx_err)
    );

    assign unused_bits = ^{wb_adr_i[15:2], wb_adr_i[0], wb_dat_i[13:7], wb_dat_i[5:0],
                           wb_sel_i[1], CsrOffset};

    assign empty    = (count_q == '0);
    assign full     = (count_q == CntW'(FIFO_DEPTH));
    assign bus_req  = wb_cyc_i & wb_stb_i & ~ack_q;
    assign sel_data = (wb_adr_i[1] == DataOffset[1]);
    assign data_rd  = bus_req & ~wb_we_i & sel_data;
    assign csr_wr   = bus_req & wb_we_i & ~sel_data & wb_sel_i[0];

    // An empty FIFO read that coincides with a push hands the incoming byte straight through.
    assign pop     = data_rd & (~empty | rx_valid);
    assign wr_en   = rx_valid & (~full | pop);
    assign ovf_set = rx_valid & full & ~pop;
    assign head    = empty ? rx_byte : fifo_q[rd_ptr_q];

    always_comb begin
        csr_rd             = '0;
        csr_rd[CsrErrBit]  = err_q;
        csr_rd[CsrOvfBit]  = ovf_q;
        csr_rd[CsrDoneBit] = ~empty;
        csr_rd[CsrIeBit]   = ie_q;
        if (sel_data) begin
            rd_val = pop ? {8'h00, head} : 16'h0000;
        end else begin
            rd_val = csr_rd;
        end
    end

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CntW'(1);
        end

        ie_d  = csr_wr ? wb_dat_i[CsrIeBit] : ie_q;
        err_d = (err_q & ~(csr_wr & wb_dat_i[CsrErrBit])) | rx_err;
        ovf_d = (ovf_q & ~(csr_wr & wb_dat_i[CsrOvfBit])) | ovf_set;

        // Pending follows the next-state condition so irq reacts one cycle after its cause.
        cond_d = ie_d & (count_d != '0);
        pend_d = pend_q;
        if (!cond_d) begin
            pend_d = 1'b0;
        end else if (!cond_q || pop) begin
            pend_d = 1'b1;
        end else if (iack) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ie_q     <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            cond_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            ack_q   <= bus_req;
            dat_q   <= (bus_req && !wb_we_i) ? rd_val : 16'h0000;
            count_q <= count_d;
            ie_q    <= ie_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            cond_q  <= cond_d;
            pend_q  <= pend_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            fifo_q[wr_ptr_q] <= rx_byte;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign irq      = pend_q;

endmodule

// File: tb/tb_ps2_kbd.sv
// Scoreboard bench for ps2_kbd: bus reads queue expected data, a monitor checks on each read ack.
module tb_ps2_kbd;

    localparam int unsigned Tmo = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] adr = '0;
    logic [15:0] dat_i = '0;
    logic [15:0] dat_o;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic        stb = 1'b0;
    logic        ack;
    logic [1:0]  sel = 2'b11;
    logic        irq;
    logic        iack = 1'b0;
    logic        kclk = 1'b1;
    logic        kdat = 1'b1;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] exp_q [$];
    string       name_q [$];
    logic [15:0] mon_exp;
    string       mon_name;

    ps2_kbd #(
        .FIFO_DEPTH (8),
        .FILT_LEN   (4),
        .TIMEOUT    (Tmo)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_dat_o (dat_o),
        .wb_cyc_i (cyc),
        .wb_we_i  (we),
        .wb_stb_i (stb),
        .wb_ack_o (ack),
        .wb_sel_i (sel),
        .irq      (irq),
        .iack     (iack),
        .ps2_clk  (kclk),
        .ps2_data (kdat)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (ack && !we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_read_ack: got %h want no ack", dat_o);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if (dat_o === mon_exp) n_pass++;
                else $display("FAIL %s: got %h want %h", mon_name, dat_o, mon_exp);
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_cycle(input logic [15:0] a, input logic w, input logic [15:0] d,
                             output logic got);
        got = 1'b0;
        @(posedge clk); #1;
        adr = a; we = w; dat_i = d; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [15:0] e, input string nm);
        logic got;
        exp_q.push_back(e);
        name_q.push_back(nm);
        bus_cycle(a, 1'b0, 16'h0, got);
        if (!got) begin
            n_checks++;
            $display("FAIL %s_ack: got no ack want ack", nm);
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        logic got;
        bus_cycle(a, 1'b1, d, got);
        n_checks++;
        if (got) n_pass++;
        else $display("FAIL write_ack @%h: got no ack want ack", a);
    endtask

    task automatic check_irq(input logic e, input string nm);
        n_checks++;
        if (irq === e) n_pass++;
        else $display("FAIL %s: got irq=%b want irq=%b", nm, irq, e);
    endtask

    task automatic ps2_bit(input logic b);
        kdat = b;
        repeat (10) @(posedge clk);
        kclk = 1'b0;
        repeat (20) @(posedge clk);
        kclk = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(1'b1);
        kdat = 1'b1;
        wait_clks(20);
    endtask

    task automatic pulse_iack();
        @(posedge clk); #1;
        iack = 1'b1;
        @(posedge clk); #1;
        iack = 1'b0;
        wait_clks(1);
    endtask

    initial begin
        wait_clks(5);
        rst = 1'b0;
        wait_clks(2);

        check_irq(1'b0, "reset_irq");
        bus_read(16'd0, 16'h0000, "reset_csr");

        send_frame(8'h1C, 1'b0);
        bus_read(16'd0, 16'h0080, "csr_done");
        bus_read(16'd2, 16'h001C, "data_1c");
        bus_read(16'd0, 16'h0000, "csr_after_pop");

        bus_write(16'd0, 16'h0040);
        bus_read(16'd0, 16'h0040, "csr_ie");
        check_irq(1'b0, "irq_ie_empty");
        send_frame(8'hF0, 1'b0);
        check_irq(1'b1, "irq_after_push");
        pulse_iack();
        check_irq(1'b0, "irq_after_iack");
        bus_read(16'd2, 16'h00F0, "data_f0");
        check_irq(1'b0, "irq_after_read");

        send_frame(8'h33, 1'b0);
        send_frame(8'h44, 1'b0);
        check_irq(1'b1, "irq_two_bytes");
        pulse_iack();
        check_irq(1'b0, "irq_iack_two");
        bus_read(16'd2, 16'h0033, "data_33");
        check_irq(1'b1, "irq_rearm_pop");
        pulse_iack();
        bus_read(16'd2, 16'h0044, "data_44");
        check_irq(1'b0, "irq_drained");
        bus_write(16'd0, 16'h0000);

        send_frame(8'h1C, 1'b1);
        bus_read(16'd0, 16'h8000, "csr_err");
        bus_write(16'd0, 16'h8000);
        bus_read(16'd0, 16'h0000, "csr_err_clr");

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
        bus_read(16'd0, 16'h4080, "csr_ovf");
        for (int i = 1; i <= 8; i++) bus_read(16'd2, 16'(i), "data_ovf_seq");
        bus_read(16'd2, 16'h0000, "data_empty");
        bus_read(16'd0, 16'h4000, "csr_ovf_empty");
        bus_write(16'd0, 16'h4000);
        bus_read(16'd0, 16'h0000, "csr_ovf_clr");

        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        kdat = 1'b1;
        wait_clks(Tmo + 10);
        send_frame(8'h5A, 1'b0);
        bus_read(16'd0, 16'h0080, "csr_after_timeout");
        bus_read(16'd2, 16'h005A, "data_5a");
        bus_read(16'd0, 16'h0000, "csr_timeout_empty");

        bus_write(16'd0, 16'h0040);
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        send_frame(8'h33, 1'b0);
        check_irq(1'b1, "irq_before_reset");
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        kdat = 1'b1;
        wait_clks(3);
        check_irq(1'b0, "irq_in_reset");
        rst = 1'b0;
        wait_clks(2);
        check_irq(1'b0, "irq_after_reset");
        bus_read(16'd0, 16'h0000, "csr_after_reset");
        send_frame(8'h5B, 1'b0);
        bus_read(16'd0, 16'h0080, "csr_post_reset_frame");
        bus_read(16'd2, 16'h005B, "data_5b");

        wait_clks(4);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
